// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder - byte FIFO plus launch sequencer feeding one frame at a time into uart_tx.
// Holds each launch until the transmitter reports done, with optional idle gap and ack timeout.
module uart_tx_feeder #(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int GAP_CLKS    = 0,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  input  logic          flush,
  output logic          tx_activate,
  output logic [7:0]    tx_data,
  input  logic          tx_active,
  input  logic          tx_done,
  output logic [AW:0]   level,
  output logic          busy,
  output logic          overflow,
  output logic          ack_err
);

  localparam int ACW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam int GCW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS + 1) : 1;
  localparam logic [ACW-1:0] ACK_LAST = ACW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam logic [GCW-1:0] GAP_LAST = GCW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
  localparam logic [AW:0]    FULL     = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_ACK  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_WAIT_REL  = 3'd4,
    S_GAP       = 3'd5
  } state_t;

  state_t          state_q;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic            rdy_en_q;
  logic            overflow_q, overflow_d;
  logic            ack_err_q;
  logic [ACW-1:0]  ack_cnt_q;
  logic [GCW-1:0]  gap_cnt_q;
  logic            tx_activate_q;
  logic [7:0]      tx_data_q;
  logic            push, pop, full, ack_expire;

  // rdy_en_q keeps in_ready low until the first edge after reset release
  assign full       = (level_q == FULL);
  assign in_ready   = rdy_en_q & (level_q < FULL) & ~flush;
  assign push       = in_valid & in_ready;
  assign pop        = (state_q == S_IDLE) & (level_q != '0) & ~tx_active & ~tx_done & ~flush;
  assign ack_expire = (state_q == S_WAIT_ACK) & ~tx_active & (ack_cnt_q >= ACK_LAST);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      if (rdy_en_q & in_valid & full) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      rdy_en_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      rdy_en_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      tx_activate_q <= 1'b0;
      tx_data_q     <= 8'h00;
      ack_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      ack_err_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_activate_q <= 1'b0;
          if (pop) begin
            state_q       <= S_LAUNCH;
            tx_activate_q <= 1'b1;
            tx_data_q     <= mem[rd_ptr_q];
          end
        end
        S_LAUNCH: begin
          tx_activate_q <= 1'b0;
          ack_cnt_q     <= '0;
          state_q       <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (tx_active)       state_q   <= S_WAIT_DONE;
          else if (ack_expire) state_q   <= S_IDLE;
          else                 ack_cnt_q <= ack_cnt_q + 1'b1;
        end
        S_WAIT_DONE: begin
          if (tx_done) state_q <= S_WAIT_REL;
        end
        S_WAIT_REL: begin
          if (!tx_done) begin
            gap_cnt_q <= '0;
            state_q   <= (GAP_CLKS > 0) ? S_GAP : S_IDLE;
          end
        end
        S_GAP: begin
          if (gap_cnt_q >= GAP_LAST) state_q   <= S_IDLE;
          else                       gap_cnt_q <= gap_cnt_q + 1'b1;
        end
        default: begin
          state_q       <= S_IDLE;
          tx_activate_q <= 1'b0;
        end
      endcase
      if (flush)           ack_err_q <= 1'b0;
      else if (ack_expire) ack_err_q <= 1'b1;
    end
  end

  assign tx_activate = tx_activate_q;
  assign tx_data     = tx_data_q;
  assign level       = level_q;
  assign busy        = (state_q != S_IDLE) | (level_q != '0);
  assign overflow    = overflow_q;
  assign ack_err     = ack_err_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - directed bench for uart_tx_feeder with a behavioural uart_tx (4 clocks/bit).
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int GAP   = 5;
  localparam int ACKT  = 8;
  localparam int CPB   = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          flush;
  logic          tx_activate;
  logic [7:0]    tx_data;
  logic          tx_active_w;
  logic          tx_done_w;
  logic [AW:0]   level;
  logic          busy;
  logic          overflow;
  logic          ack_err;

  logic stub = 1'b0;
  logic hold_active = 1'b0;

  int total = 0;
  int bad   = 0;
  int act_cnt = 0;
  int guard_bad = 0;
  logic act_prev = 1'b0;
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  uart_tx_feeder #(.DEPTH(DEPTH), .AW(AW), .GAP_CLKS(GAP), .ACK_TIMEOUT(ACKT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .flush(flush), .tx_activate(tx_activate), .tx_data(tx_data), .tx_active(tx_active_w),
    .tx_done(tx_done_w), .level(level), .busy(busy), .overflow(overflow), .ack_err(ack_err)
  );

  // Behavioural transmitter without reset: START, 8 data bits, STOP, then done for two clocks.
  typedef enum {U_IDLE, U_START, U_DATA, U_STOP, U_CLEAN} ust_t;
  ust_t u_st = U_IDLE;
  int   u_cnt = 0;
  int   u_bit = 0;
  logic u_active = 1'b0;
  logic u_done = 1'b0;

  assign tx_active_w = stub ? 1'b0 : (u_active | hold_active);
  assign tx_done_w   = stub ? 1'b0 : u_done;

  always @(posedge clk) begin
    case (u_st)
      U_IDLE: begin
        u_done <= 1'b0;
        u_cnt  <= 0;
        u_bit  <= 0;
        if (tx_activate && !stub) begin
          u_active <= 1'b1;
          rx_q.push_back(tx_data);
          u_st <= U_START;
        end else begin
          u_active <= 1'b0;
        end
      end
      U_START: begin
        if (u_cnt < CPB - 1) u_cnt <= u_cnt + 1;
        else begin u_cnt <= 0; u_st <= U_DATA; end
      end
      U_DATA: begin
        if (u_cnt < CPB - 1) u_cnt <= u_cnt + 1;
        else begin
          u_cnt <= 0;
          if (u_bit < 7) u_bit <= u_bit + 1;
          else begin u_bit <= 0; u_st <= U_STOP; end
        end
      end
      U_STOP: begin
        if (u_cnt < CPB - 1) u_cnt <= u_cnt + 1;
        else begin
          u_cnt    <= 0;
          u_done   <= 1'b1;
          u_active <= 1'b0;
          u_st     <= U_CLEAN;
        end
      end
      default: begin
        u_done <= 1'b1;
        u_st   <= U_IDLE;
      end
    endcase
  end

  // Launch monitor: pulse width and launch-into-busy-transmitter guard
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_activate) begin
        act_cnt = act_cnt + 1;
        if (tx_active_w || tx_done_w) guard_bad = guard_bad + 1;
        if (act_prev) guard_bad = guard_bad + 1;
      end
      act_prev = tx_activate;
    end else begin
      act_prev = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input logic want, input int max, input string tag);
    int n = 0;
    while (tx_done_w !== want && n < max) begin tick(); n++; end
    chk(tag, {31'd0, tx_done_w}, {31'd0, want});
  endtask

  task automatic wait_idle(input int max, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < max) begin tick(); n++; end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_act(input int max, input string tag);
    int n = 0;
    while (tx_activate !== 1'b1 && n < max) begin tick(); n++; end
    chk(tag, {31'd0, tx_activate}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_activate", {31'd0, tx_activate}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_level", {27'd0, level}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_ack_err", {31'd0, ack_err}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // 1: single byte, launch in cycle k+2
    rx_q.delete();
    push(8'hA5);
    chk("t1_act_k", {31'd0, tx_activate}, 32'd0);
    chk("t1_level_k", {27'd0, level}, 32'd1);
    tick();
    chk("t1_act_k1", {31'd0, tx_activate}, 32'd1);
    chk("t1_tx_data", {24'd0, tx_data}, 32'hA5);
    chk("t1_level_pop", {27'd0, level}, 32'd0);
    tick();
    chk("t1_act_pulse_end", {31'd0, tx_activate}, 32'd0);
    wait_done(1'b1, 100, "t1_done_rise");
    wait_done(1'b0, 10, "t1_done_fall");
    chk("t1_busy_at_fall", {31'd0, busy}, 32'd1);
    wait_idle(50, "t1_idle");
    chk("t1_rx_cnt", rx_q.size(), 32'd1);
    chk("t1_rx_byte", {24'd0, rx_q[0]}, 32'hA5);
    chk("t1_act_cnt", act_cnt, 32'd1);

    // 2: fill with transmitter held busy, overflow on 17th push, then drain in order
    rx_q.delete();
    hold_active = 1'b1;
    base = act_cnt;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      tick();
    end
    in_data = 8'h11;
    chk("t2_ready_full", {31'd0, in_ready}, 32'd0);
    chk("t2_level_full", {27'd0, level}, 32'd16);
    chk("t2_ovf_before", {31'd0, overflow}, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("t2_ovf_set", {31'd0, overflow}, 32'd1);
    chk("t2_level_kept", {27'd0, level}, 32'd16);
    chk("t2_no_launch_held", act_cnt - base, 32'd0);
    hold_active = 1'b0;
    wait_idle(1500, "t2_idle");
    chk("t2_rx_cnt", rx_q.size(), 32'd16);
    for (int i = 0; i < 16; i++) chk("t2_rx_order", {24'd0, rx_q[i]}, 32'(i + 1));
    chk("t2_act_cnt", act_cnt - base, 32'd16);

    // 3: gap between done falling and next launch is WAIT_REL + IDLE + GAP clocks
    rx_q.delete();
    push(8'h3C);
    push(8'hC3);
    wait_done(1'b1, 100, "t3_done_rise");
    wait_done(1'b0, 10, "t3_done_fall");
    n = 0;
    while (tx_activate !== 1'b1 && n < 50) begin tick(); n++; end
    chk("t3_gap_clks", n, 32'(GAP + 2));
    wait_idle(100, "t3_idle");
    chk("t3_rx_cnt", rx_q.size(), 32'd2);
    chk("t3_rx_second", {24'd0, rx_q[1]}, 32'hC3);

    // 4: no ack from transmitter -> timeout, byte dropped, next byte launched
    stub = 1'b1;
    push(8'h5A);
    push(8'h3C);
    wait_act(10, "t4_launch");
    repeat (8) tick();
    chk("t4_err_not_yet", {31'd0, ack_err}, 32'd0);
    tick();
    chk("t4_err_set", {31'd0, ack_err}, 32'd1);
    tick();
    chk("t4_next_launch", {31'd0, tx_activate}, 32'd1);
    chk("t4_next_data", {24'd0, tx_data}, 32'h3C);
    wait_idle(30, "t4_idle");
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_flush_err", {31'd0, ack_err}, 32'd0);
    chk("t4_flush_ovf", {31'd0, overflow}, 32'd0);
    stub = 1'b0;

    // 5: reset mid-frame, next launch must wait for transmitter to finish
    rx_q.delete();
    push(8'h77);
    wait_act(10, "t5_launch");
    repeat (10) tick();
    chk("t5_midframe", {31'd0, tx_active_w}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ready", {31'd0, in_ready}, 32'd0);
    chk("t5_rst_data", {24'd0, tx_data}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("t5_rel_ready", {31'd0, in_ready}, 32'd1);
    base = act_cnt;
    push(8'h99);
    chk("t5_held_back", act_cnt - base, 32'd0);
    wait_done(1'b1, 60, "t5_done_rise");
    wait_done(1'b0, 5, "t5_done_fall");
    wait_act(20, "t5_launch_after");
    wait_idle(100, "t5_idle");
    chk("t5_rx_cnt", rx_q.size(), 32'd2);
    chk("t5_rx_byte", {24'd0, rx_q[1]}, 32'h99);

    // 6: flush while queued behind an in-flight frame
    rx_q.delete();
    push(8'h11);
    wait_act(10, "t6_launch");
    repeat (5) tick();
    for (int i = 0; i < 4; i++) push(8'(8'h21 + i));
    chk("t6_level_queued", {27'd0, level}, 32'd4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t6_level_flushed", {27'd0, level}, 32'd0);
    chk("t6_busy_inflight", {31'd0, busy}, 32'd1);
    base = act_cnt;
    wait_idle(100, "t6_idle");
    repeat (60) tick();
    chk("t6_no_more_launch", act_cnt - base, 32'd0);
    chk("t6_rx_cnt", rx_q.size(), 32'd1);
    chk("t6_rx_byte", {24'd0, rx_q[0]}, 32'h11);

    chk("guard_violations", guard_bad, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
